// File: rtl/pwm_capture.sv
// pwm_capture: samples one asynchronous input pin, measures high time and
// period in clock cycles and queues {high, period} words in a small
// first-word-fall-through FIFO drained with a pop strobe.
// Optional glitch filter enabled with the macro PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
    parameter int CNT_W = 16,
    parameter int DEPTH = 4,
    parameter int SYNC  = 2,
    parameter int FILT  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               pin,
    input  logic               pop,
    output logic [2*CNT_W-1:0] dout,
    output logic               rx_empty,
    output logic               rx_full,
    output logic               overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_LOW  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Parameter legality is checked while elaborating.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || SYNC < 2 || FILT < 1) begin : g_param_chk
        $error("pwm_capture: illegal parameter set");
    end

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // ---------------- input conditioning ----------------
    logic [SYNC-1:0] sync_q, sync_d;
    logic            sync_s;
    logic            s_s;
    logic            s_d_q, s_d_d;
    logic            rise_s, fall_s;

    // Shift the raw pin into the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[SYNC-2:0], pin};
    end

    // Synchroniser flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC{1'b0}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_s = sync_q[SYNC-1];

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int FW = $clog2(FILT + 1);
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic          flt_q, flt_d;

    // Accept a new level only after it has persisted for FILT cycles.
    always_comb begin
        flt_d     = flt_q;
        flt_cnt_d = flt_cnt_q;
        if (sync_s == flt_q) begin
            flt_cnt_d = {FW{1'b0}};
        end else if (flt_cnt_q == FW'(FILT - 1)) begin
            flt_d     = sync_s;
            flt_cnt_d = {FW{1'b0}};
        end else begin
            flt_cnt_d = flt_cnt_q + FW'(1);
        end
    end

    // Filter state flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            flt_q     <= 1'b0;
            flt_cnt_q <= {FW{1'b0}};
        end else begin
            flt_q     <= flt_d;
            flt_cnt_q <= flt_cnt_d;
        end
    end

    assign s_s = flt_q;
`else
    assign s_s = sync_s;
`endif

    // Delayed copy of the conditioned input for edge detection.
    always_comb begin
        s_d_d = s_s;
    end

    assign rise_s = s_s & ~s_d_q;
    assign fall_s = ~s_s & s_d_q;

    // ---------------- measurement FSM ----------------
    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   hi_lat_q, hi_lat_d;
    logic               push_s;
    logic [2*CNT_W-1:0] push_word_s;

    // Next-state logic: arm on first rise, latch high time on fall, push on next rise.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_lat_d    = hi_lat_q;
        push_s      = 1'b0;
        push_word_s = {hi_lat_q, cnt_q};
        if (!en) begin
            state_d  = ST_IDLE;
            cnt_d    = CNT_ZERO;
            hi_lat_d = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (rise_s) begin
                        cnt_d   = CNT_ONE;
                        state_d = ST_HIGH;
                    end else begin
                        state_d = ST_ARM;
                    end
                end
                ST_HIGH: begin
                    cnt_d = sat_inc(cnt_q);
                    if (fall_s) begin
                        hi_lat_d = cnt_q;
                        state_d  = ST_LOW;
                    end else begin
                        state_d  = ST_HIGH;
                    end
                end
                ST_LOW: begin
                    if (rise_s) begin
                        push_s  = 1'b1;
                        cnt_d   = CNT_ONE;
                        state_d = ST_HIGH;
                    end else begin
                        cnt_d   = sat_inc(cnt_q);
                        state_d = ST_LOW;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    cnt_d    = CNT_ZERO;
                    hi_lat_d = CNT_ZERO;
                end
            endcase
        end
    end

    // Measurement and edge-detect flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= CNT_ZERO;
            hi_lat_q <= CNT_ZERO;
            s_d_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_lat_q <= hi_lat_d;
            s_d_q    <= s_d_d;
        end
    end

    // ---------------- FIFO ----------------
    logic [2*CNT_W-1:0] mem_q [DEPTH];
    logic [2*CNT_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]      count_q, count_d;
    logic               pop_ok_s, push_ok_s;
    logic [2*CNT_W-1:0] dout_q, dout_d;
    logic               empty_q, empty_d, full_q, full_d, ovf_q, ovf_d;

    // FIFO bookkeeping; a pop frees room for a simultaneous push when full.
    always_comb begin
        pop_ok_s  = pop & (count_q != {OW{1'b0}});
        push_ok_s = push_s & ((count_q != OW'(DEPTH)) | pop_ok_s);
        ovf_d     = ovf_q | (push_s & ~push_ok_s);
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = (push_ok_s && (wr_ptr_q == AW'(i))) ? push_word_s : mem_q[i];
        end
        wr_ptr_d = push_ok_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + OW'(1);
            2'b01:   count_d = count_q - OW'(1);
            default: count_d = count_q;
        endcase
        dout_d  = mem_d[rd_ptr_d];
        empty_d = (count_d == {OW{1'b0}});
        full_d  = (count_d == OW'(DEPTH));
    end

    // FIFO storage, pointers and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {(2*CNT_W){1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {OW{1'b0}};
            dout_q   <= {(2*CNT_W){1'b0}};
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    assign dout     = dout_q;
    assign rx_empty = empty_q;
    assign rx_full  = full_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture: random and directed PWM waveforms compared
// against a period-level reference model of the measurement FIFO.
module tb_pwm_capture;

    localparam int CNT_W = 16;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int FILT  = 4;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int PUSH_LAT = SYNC + 1 + FILT;
`else
    localparam int PUSH_LAT = SYNC + 1;
`endif
    localparam int TAIL = PUSH_LAT + 6;

    logic        clk = 1'b0;
    logic        reset, en, pin, pop;
    logic [31:0] dout;
    logic        rx_empty, rx_full, overflow;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    bit          exp_ovf;

    pwm_capture #(.CNT_W(CNT_W), .DEPTH(DEPTH), .SYNC(SYNC), .FILT(FILT)) dut (
        .clk(clk), .reset(reset), .en(en), .pin(pin), .pop(pop),
        .dout(dout), .rx_empty(rx_empty), .rx_full(rx_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int h, input int l);
        int hs, ps;
        hs = (h > 65535) ? 65535 : h;
        ps = (h + l > 65535) ? 65535 : h + l;
        return {hs[15:0], ps[15:0]};
    endfunction

    task automatic model_push(input int h, input int l);
        if (exp_q.size() < DEPTH) exp_q.push_back(model_word(h, l));
        else exp_ovf = 1'b1;
    endtask

    task automatic drive(input bit v, input int c);
        pin = v;
        repeat (c) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; en = 1'b0; pin = 1'b0; pop = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        @(negedge clk);
    endtask

    // Each complete high/low pair is pushed by the rise that follows it.
    task automatic play(input int hs[$], input int ls[$]);
        en = 1'b1;
        drive(1'b0, 8);
        for (int i = 0; i < hs.size(); i++) begin
            drive(1'b1, hs[i]);
            drive(1'b0, ls[i]);
        end
        drive(1'b1, TAIL);
        for (int i = 0; i < hs.size(); i++) model_push(hs[i], ls[i]);
        en = 1'b0;
        drive(1'b0, 8);
    endtask

    task automatic check_flags(input string tag);
        check_eq({tag, "_empty"}, {31'd0, rx_empty}, {31'd0, exp_q.size() == 0});
        check_eq({tag, "_full"}, {31'd0, rx_full}, {31'd0, exp_q.size() == DEPTH});
        check_eq({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() > 0) begin
            check_eq($sformatf("%s_nempty%0d", tag, k), {31'd0, rx_empty}, 32'd0);
            check_eq($sformatf("%s_dout%0d", tag, k), dout, exp_q.pop_front());
            pop = 1'b1;
            @(negedge clk);
            pop = 1'b0;
            k++;
        end
        check_eq({tag, "_drained"}, {31'd0, rx_empty}, 32'd1);
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        @(negedge clk);
        check_eq({tag, "_pop_empty"}, {31'd0, rx_empty}, 32'd1);
        check_eq({tag, "_pop_empty_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs[$], ls[$];
        int h4, l4;
        reset = 1'b0; en = 1'b0; pin = 1'b0; pop = 1'b0;

        // Reset state
        do_reset();
        check_eq("rst_empty", {31'd0, rx_empty}, 32'd1);
        check_eq("rst_full", {31'd0, rx_full}, 32'd0);
        check_eq("rst_ovf", {31'd0, overflow}, 32'd0);
        check_eq("rst_dout", dout, 32'd0);

        // 30/50 waveform, three rises -> two words
        hs = '{30, 30}; ls = '{50, 50};
        play(hs, ls);
        check_flags("basic");
        drain("basic");

        // Six periods, no pop -> four held plus overflow
        do_reset();
        hs.delete(); ls.delete();
        for (int i = 0; i < 5; i++) begin
            hs.push_back($urandom_range(6, 40));
            ls.push_back($urandom_range(6, 40));
        end
        play(hs, ls);
        check_flags("ovf");
        drain("ovf");

        // Pop in the same cycle as a push while full
        do_reset();
        en = 1'b1;
        drive(1'b0, 8);
        for (int i = 0; i < 4; i++) begin
            hs[i] = $urandom_range(6, 20);
            ls[i] = $urandom_range(6, 20);
            drive(1'b1, hs[i]);
            drive(1'b0, ls[i]);
            if (i > 0) model_push(hs[i-1], ls[i-1]);
        end
        h4 = $urandom_range(PUSH_LAT + 2, 20);
        l4 = $urandom_range(6, 20);
        drive(1'b1, h4);
        model_push(hs[3], ls[3]);
        drive(1'b0, l4);
        check_eq("pp_full_before", {31'd0, rx_full}, 32'd1);
        pin = 1'b1;
        repeat (PUSH_LAT - 1) @(posedge clk);
        @(negedge clk);
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        void'(exp_q.pop_front());
        model_push(h4, l4);
        drive(1'b1, 10);
        en = 1'b0;
        drive(1'b0, 4);
        check_flags("pushpop");
        drain("pushpop");

        // Saturation
        do_reset();
        hs = '{70000}; ls = '{10};
        play(hs, ls);
        check_flags("sat");
        drain("sat");

        // Short glitch inside the low phase of a 30/50 waveform
        do_reset();
        en = 1'b1;
        drive(1'b0, 8);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 30); drive(1'b0, 20); drive(1'b1, 2); drive(1'b0, 28);
        end
        drive(1'b1, TAIL);
`ifdef PWM_CAPTURE_FILTER_EN
        model_push(30, 50); model_push(30, 50);
`else
        model_push(30, 20); model_push(2, 28); model_push(30, 20); model_push(2, 28);
`endif
        en = 1'b0;
        drive(1'b0, 8);
        check_flags("glitch");
        drain("glitch");

        // Drop en mid-high, re-enable; earlier word retained
        do_reset();
        en = 1'b1;
        drive(1'b0, 8);
        drive(1'b1, 25); drive(1'b0, 35); drive(1'b1, 20);
        model_push(25, 35);
        en = 1'b0;
        drive(1'b1, 5);
        en = 1'b1;
        drive(1'b1, 15); drive(1'b0, 30);
        drive(1'b1, 22); drive(1'b0, 18);
        drive(1'b1, 33); drive(1'b0, 27);
        drive(1'b1, TAIL);
        model_push(22, 18); model_push(33, 27);
        en = 1'b0;
        drive(1'b0, 8);
        check_flags("endrop");
        drain("endrop");

        // Randomized waveforms
        for (int t = 0; t < 8; t++) begin
            do_reset();
            hs.delete(); ls.delete();
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
                hs.push_back($urandom_range(FILT + 1, 60));
                ls.push_back($urandom_range(FILT + 1, 60));
            end
            play(hs, ls);
            check_flags($sformatf("rnd%0d", t));
            drain($sformatf("rnd%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Receive-side counterpart to the PIO PWM generator: samples one GPIO input, measures high time and period in system-clock cycles, and queues each completed measurement as a 32-bit word in a small first-word-fall-through FIFO. It sits beside `pio` on the `gpio_out` side, either looped back for self-test or on an external pin. The host drains it with a pop strobe, using the same `dout`/`rx_empty` style as the PIO RX path.

## Interface
- `CNT_W`, 16: width of the high and period counters; `dout` is 2*`CNT_W`.
- `DEPTH`, 4: FIFO entries, power of two ≥ 2.
- `SYNC`, 2: synchroniser flops on `pin`, ≥ 2.
- `FILT`, 4: glitch-filter length in cycles; used only with `PWM_CAPTURE_FILTER_EN`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `en`  in  1  capture enable, level.
- `pin`  in  1  asynchronous input, for example `gpio_out[0]` looped back.
- `pop`  in  1  one-cycle strobe; removes the FIFO head.
- `dout`  out  2*`CNT_W`  FIFO head: {high[`CNT_W`-1:0], period[`CNT_W`-1:0]}.
- `rx_empty`  out  1  FIFO empty.
- `rx_full`  out  1  FIFO full.
- `overflow`  out  1  sticky; a measurement was dropped.

## Operation
- **Input conditioning:** `pin` → `SYNC`-flop synchroniser → `s` (optionally filtered) → `s_d`.
  - rise = `s & ~s_d`
  - fall = `~s & s_d`
- **States:**
  - IDLE:
    - Entered on reset.
    - Entered from any state when `en`=0; this also clears `cnt` and `hi_lat`.
    - Goes to ARM when `en`=1.
  - ARM: waits for rise. A partial first period is never reported.
    - On rise: `cnt`←1, go to HIGH.
  - HIGH:
    - Each cycle `cnt`←`cnt`+1.
    - On fall: `hi_lat`←`cnt`, `cnt`←`cnt`+1, go to LOW.
  - LOW:
    - Each cycle `cnt`←`cnt`+1.
    - On rise: push {`hi_lat`, `cnt`}, then `cnt`←1, go to HIGH.
- **Result:** for an input high for H cycles and low for L cycles, each word is {H, H+L}.
- **Arithmetic:** `cnt` saturates at 2^`CNT_W`−1 and never wraps. Saturated values are pushed as-is; the host treats all-ones as "≥ limit".
- **FIFO:** `DEPTH` entries. `dout` always shows the head and is valid whenever `rx_empty`=0. Contents are undefined when empty.
  - Pop while empty: ignored.
  - Push while full without pop: the new word is dropped and `overflow`←1. Existing contents are unchanged.
  - Push and pop in the same cycle while full: both take effect, occupancy is unchanged, no overflow.
  - Push and pop in the same cycle while empty: the push takes effect and the pop is ignored.
- **`en` deasserted:** FIFO contents and `overflow` are preserved; only the measurement state is discarded.
- **`overflow`** clears only on `reset`.

## Timing
- Reset values:
  - `rx_empty`=1, `rx_full`=0, `overflow`=0.
  - `dout`=0; the storage is cleared.
  - State IDLE; `cnt` and `hi_lat` are 0.
  - Synchroniser and filter flops are 0.
- Latency from a `pin` edge to the internal rise/fall: `SYNC`+1 cycles, plus `FILT` cycles with the filter. Both edges are delayed equally, so H and P are unaffected.
- A push lands on the clock edge after the rise cycle. `rx_empty` falls and `dout` is valid one cycle after that rise.
- After pop: the next entry appears on `dout` on the following cycle.
- Minimum measurable widths are H ≥ 1 and L ≥ 1 synchronised cycles (H ≥ `FILT` and L ≥ `FILT` with the filter).
- `reset` mid-measurement: everything returns to reset values on the next edge, including FIFO contents.

## Configuration
- `PWM_CAPTURE_FILTER_EN` defined:
  - `s` changes only after the synchronised input has held a new value for `FILT` consecutive cycles.
  - Pulses shorter than `FILT` are ignored entirely.
- Not defined:
  - `s` is the synchroniser output and `FILT` is unused.
  - Every synchronised transition is an edge.

## Test plan
- Reset, then `en`=1 with `pin` high 30 / low 50 cycles, three periods:
  - The first rise only arms; no word is pushed for it.
  - The next two rises each push {30, 80}, so two words are pushed.
  - `overflow`=0.
- Loopback from a PIO PWM driving `gpio_out[0]`, with div 0x0280 and duty sequence 2, 4: words match the PIO high and period counts computed from the divider.
- Run 6 periods (5 pushes) with no pop and `DEPTH`=4:
  - Four words are held.
  - `rx_full`=1 and `overflow`=1.
  - The first four words are intact on drain.
- With the FIFO full, pop in the same cycle as a push: occupancy stays 4, `overflow` stays 0, and the order is preserved.
- Hold `pin` high for 70000 cycles, then low 10: the word is {0xFFFF, 0xFFFF}, i.e. saturated, not wrapped.
- A 2-cycle glitch in the low phase of a 30/50 waveform:
  - With `PWM_CAPTURE_FILTER_EN` and `FILT`=4: words stay {30, 80}.
  - Without the macro: extra short words appear.
- Drop `en` mid-HIGH, then re-enable: the next word reflects only complete periods after re-arm, and earlier FIFO contents are retained.
